mod_addsub: RTL and testbench
=============================

# mod_addsub

Limb-serial modular adder/subtractor for the 1027-bit Montgomery datapath. It computes (a + b) mod M or (a − b) mod M for operands already reduced below M. It processes one 64-bit limb per cycle and performs the final conditional correction by M in the same pass, so no second pass is needed. It sits after the wide pipelined `mpadder` in the datapath and is the reducing counterpart to it: `mpadder` produces unreduced 1028-bit sums, and this block returns fully reduced 1027-bit residues with a start/done handshake.

## Interface
- No parameters; widths are fixed.
  - Operand width is 1027 bits.
  - Limb width is 64 bits.
  - Limb count is 17, so the internal width is 1088 bits; operands are zero-extended.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only when `busy`=0
- subtract  input  1  0: a+b mod M, 1: a−b mod M; latched with `start`
- in_a  input  1027  operand a; must satisfy a < M; latched with `start`
- in_b  input  1027  operand b; must satisfy b < M; latched with `start`
- in_m  input  1027  modulus M; must satisfy M > 1; latched with `start`
- busy  output  1  high while limbs are being processed
- done  output  1  one-cycle pulse; `result` is valid from this cycle on
- result  output  1027  reduced result, held until the next accepted `start` completes

## Operation
- The block has three states: IDLE, RUN and DONE.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→DONE after limb 16 is processed.
  - DONE→RUN if `start` is high, otherwise DONE→IDLE.
- On accept, the block captures a, b and M into 1088-bit shift registers (zero-extended). It also captures `subtract`, clears the limb counter, and initialises the carries:
  - c1 = `subtract`.
  - c2 = NOT `subtract`.
- Per RUN cycle, for limb i (0..16), with x' meaning bitwise-inverted x:
  - b* = b_i' if subtracting, else b_i.
  - m* = m_i' if adding, else m_i.
  - {c1, s_i} = a_i + b* + c1 (65-bit).
  - {c2, t_i} = s_i + m* + c2 (65-bit).
  - s_i and t_i shift into the S and T registers. The a, b and M registers shift right by 64 bits.
- Both chains are full 1088-bit two's-complement arithmetic; no intermediate value is truncated to 1027 bits.
  - Add path: S = a+b and T = S−M.
  - Sub path: S = a−b mod 2^1088 and T = S+M.
- Selection, made in the limb-16 cycle using the final carries:
  - Add: result = T[1026:0] if final c2=1 (S ≥ M, no borrow), else S[1026:0].
  - Sub: result = T[1026:0] if final c1=0 (a < b, borrow), else S[1026:0].
- `result` register loads on the edge ending the limb-16 cycle. It is unchanged at all other times.
- Preconditions a,b < M are not checked; if violated, the output is undefined but the handshake timing is unchanged.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, carries 0, limb counter 0.
- Latency:
  - `start` high in cycle 0 (IDLE or DONE) → RUN in cycles 1..17 → `done`=1 in cycle 18.
  - Throughput is one operation per 18 cycles.
- `busy` is 1 exactly in cycles 1..17. `done` is 1 only in cycle 18 and is never asserted together with `busy`.
- `start` while `busy`=1 is ignored: operands are not re-latched and the sequence is not disturbed.
- `start` in the DONE cycle is accepted (back-to-back operation). `result` from the previous operation stays stable until the new one's limb-16 edge.
- Input ports may change freely after the accept cycle.
- `rst` asserted in any cycle takes effect at the next edge:
  - The operation is aborted and no `done` is produced.
  - `result` returns to 0.
  - A `start` in the same cycle as `rst` is discarded.

## Test plan
- Add, M=11, a=5, b=7, `start` in cycle 0 → `busy` high in cycles 1..17, `done` in cycle 18, `result`=1.
- Sub, M=11, a=3, b=8 → `result`=6. Sub a=b=9 → 0. Add a=4, b=7 → 0 (sum equals M exactly).
- Wide carries: M=2^1027−1, add a=b=M−1 → 2^1027−3. M=2^1026+3, add a=2^64−1, b=1 → 2^64 (exercises the limb-0→1 carry and limb 16).
- Sub wrap-around: M=2^1027−1, a=0, b=1 → 2^1027−2. a=1, b=0 → 1.
- Handshake: `start` with new operands pulsed in cycle 5 during RUN → ignored, first `result` still correct. `start` in the DONE cycle (18) → second `done` in cycle 36; first `result` held in cycles 19..35.
- Reset: `rst` in cycle 9 of an operation → cycle 10 shows `busy`=0, `done`=0, `result`=0, and no `done` follows. A fresh `start` afterwards completes normally 18 cycles later.

Source files
------------

// File: rtl/mod_addsub.sv
// Limb-serial modular add/subtract over a 1027-bit modulus.
// One 64-bit limb per cycle; both candidate results are formed in one pass.
module mod_addsub (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          subtract,
  input  logic [1026:0] in_a,
  input  logic [1026:0] in_b,
  input  logic [1026:0] in_m,
  output logic          busy,
  output logic          done,
  output logic [1026:0] result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [1087:0] a_sh;
  logic [1087:0] b_sh;
  logic [1087:0] m_sh;
  logic [1087:0] s_sh;
  logic [1087:0] t_sh;
  logic          c1;
  logic          c2;
  logic          sub;
  logic [4:0]    cnt;

  logic          accept;
  logic          last;
  logic [63:0]   bx;
  logic [63:0]   mx;
  logic [64:0]   sum1;
  logic [64:0]   sum2;
  logic [1087:0] s_next;
  logic [1087:0] t_next;
  logic          pick_t;

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign accept = start && !busy;
  assign last   = (cnt == 5'd16);

  // S chain adds or subtracts b; T chain then removes or restores M.
  assign bx   = sub ? ~b_sh[63:0] : b_sh[63:0];
  assign mx   = sub ? m_sh[63:0] : ~m_sh[63:0];
  assign sum1 = {1'b0, a_sh[63:0]} + {1'b0, bx}
              + {64'd0, c1};
  assign sum2 = {1'b0, sum1[63:0]} + {1'b0, mx}
              + {64'd0, c2};

  assign s_next = {sum1[63:0], s_sh[1087:64]};
  assign t_next = {sum2[63:0], t_sh[1087:64]};

  // Add: take S-M when it did not borrow. Sub: take S+M when a-b borrowed.
  assign pick_t = sub ? ~sum1[64] : sum2[64];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      m_sh   <= '0;
      s_sh   <= '0;
      t_sh   <= '0;
      c1     <= 1'b0;
      c2     <= 1'b0;
      sub    <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (last) state <= DONE;
        DONE:    state <= start ? RUN : IDLE;
        default: state <= IDLE;
      endcase

      if (accept) begin
        a_sh <= {61'd0, in_a};
        b_sh <= {61'd0, in_b};
        m_sh <= {61'd0, in_m};
        sub  <= subtract;
        cnt  <= '0;
        c1   <= subtract;
        c2   <= ~subtract;
      end else if (busy) begin
        a_sh <= {64'd0, a_sh[1087:64]};
        b_sh <= {64'd0, b_sh[1087:64]};
        m_sh <= {64'd0, m_sh[1087:64]};
        s_sh <= s_next;
        t_sh <= t_next;
        c1   <= sum1[64];
        c2   <= sum2[64];
        cnt  <= cnt + 5'd1;
        if (last) begin
          result <= pick_t ? t_next[1026:0]
                           : s_next[1026:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_addsub.sv
// Bench for mod_addsub: directed and random operations against
// a plain-arithmetic modular reference, plus handshake and reset cases.
module tb_mod_addsub;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          subtract = 1'b0;
  logic [1026:0] in_a = '0;
  logic [1026:0] in_b = '0;
  logic [1026:0] in_m = '0;
  logic          busy;
  logic          done;
  logic [1026:0] result;

  int vecs = 0;
  int errs = 0;

  mod_addsub dut (
    .clk(clk), .rst(rst), .start(start),
    .subtract(subtract), .in_a(in_a),
    .in_b(in_b), .in_m(in_m), .busy(busy),
    .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [1026:0] rnd1027();
    logic [1026:0] v;
    v = '0;
    for (int i = 0; i < 33; i++)
      v = {v[994:0], 32'($urandom)};
    return v;
  endfunction

  function automatic logic [1026:0] model(
    input bit sb, input logic [1026:0] a,
    input logic [1026:0] b, input logic [1026:0] m);
    logic [1028:0] x;
    if (!sb) begin
      x = {2'b0, a} + {2'b0, b};
      if (x >= {2'b0, m}) x = x - {2'b0, m};
    end else if (a >= b) begin
      x = {2'b0, a} - {2'b0, b};
    end else begin
      x = {2'b0, a} + {2'b0, m} - {2'b0, b};
    end
    return x[1026:0];
  endfunction

  task automatic scramble();
    in_a = rnd1027();
    in_b = rnd1027();
    in_m = rnd1027();
    subtract = 1'($urandom);
  endtask

  // start in cycle 0, check busy/done per cycle and result in cycle 18.
  // ign: cycle (2..17) in which a stray start with junk is pulsed.
  task automatic do_op(input bit sb,
    input logic [1026:0] a, input logic [1026:0] b,
    input logic [1026:0] m, input int ign,
    input string name);
    logic [1026:0] exp;
    exp = model(sb, a, b, m);
    @(negedge clk);
    start = 1'b1; subtract = sb;
    in_a = a; in_b = b; in_m = m;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      start = (c == ign);
      scramble();
      vecs++;
      if (busy !== (c <= 17) || done !== (c == 18)) begin
        errs++;
        $display("FAIL %s hs c%0d: busy=%b done=%b want %b %b",
          name, c, busy, done, c <= 17, c == 18);
      end
    end
    start = 1'b0;
    vecs++;
    if (result !== exp) begin
      errs++;
      $display("FAIL %s result: got %h want %h",
        name, result, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      errs++;
      $display("FAIL reset: busy=%b done=%b res=%h want 0 0 0",
        busy, done, result);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [1026:0] mx;
    logic [1026:0] mw;
    logic [1026:0] k;
    do_op(0, 5, 7, 11, 0, "add5_7");
    do_op(1, 3, 8, 11, 0, "sub3_8");
    do_op(1, 9, 9, 11, 0, "sub9_9");
    do_op(0, 4, 7, 11, 0, "add_eqM");
    mx = '1;
    do_op(0, mx - 1, mx - 1, mx, 0, "add_wide");
    mw = '0;
    mw[1026] = 1'b1;
    mw = mw + 3;
    k = '0;
    k[63:0] = '1;
    do_op(0, k, 1, mw, 0, "add_limb");
    do_op(1, 0, 1, mx, 0, "sub_wrap");
    do_op(1, 1, 0, mx, 0, "sub_1_0");
  endtask

  task automatic test_random();
    logic [1026:0] m;
    logic [1026:0] a;
    logic [1026:0] b;
    for (int n = 0; n < 24; n++) begin
      m = rnd1027() >> $urandom_range(0, 1020);
      if (m < 2) m = m + 2;
      a = rnd1027() % m;
      b = rnd1027() % m;
      if (n % 6 == 0) b = a;
      if (n % 6 == 1) a = m - 1;
      do_op(1'(n), a, b, m, 0, "random");
    end
  endtask

  task automatic test_ignore_start();
    do_op(0, 5, 7, 11, 5, "ign_start");
    do_op(1, 2, 10, 13, 17, "ign_start17");
  endtask

  task automatic test_back_to_back();
    logic [1026:0] e1;
    logic [1026:0] e2;
    e1 = model(0, 100, 50, 127);
    e2 = model(1, 10, 90, 127);
    @(negedge clk);
    start = 1'b1; subtract = 1'b0;
    in_a = 100; in_b = 50; in_m = 127;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      start = 1'b0;
      scramble();
      if (c == 18) begin
        start = 1'b1; subtract = 1'b1;
        in_a = 10; in_b = 90; in_m = 127;
      end
      vecs++;
      if (busy !== (c != 18 && c != 36) ||
          done !== (c == 18 || c == 36)) begin
        errs++;
        $display("FAIL b2b hs c%0d: busy=%b done=%b",
          c, busy, done);
      end
      if (c >= 18) begin
        vecs++;
        if (result !== (c == 36 ? e2 : e1)) begin
          errs++;
          $display("FAIL b2b result c%0d: got %h want %h",
            c, result, c == 36 ? e2 : e1);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_rst_abort();
    bit seen;
    @(negedge clk);
    start = 1'b1; subtract = 1'b0;
    in_a = 20; in_b = 30; in_m = 37;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      errs++;
      $display("FAIL rst_abort: busy=%b done=%b res=%h want 0 0 0",
        busy, done, result);
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1;
    end
    vecs++;
    if (seen) begin
      errs++;
      $display("FAIL rst_nodone: activity after abort, want none");
    end
    do_op(0, 20, 30, 37, 0, "after_rst");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_rst_abort();
    $display("== %0d vectors applied, %0d miscompares ==",
      vecs, errs);
    $finish;
  end

endmodule
